// File: rtl/fir_cnn_pkg.sv
// Shared types and helpers for the CNN pooling stage: pool-mode and FSM
// state encodings, plus the reciprocal constant used for averaging.
package fir_cnn_pkg;

    typedef enum logic {
        POOL_AVG = 1'b0,
        POOL_MAX = 1'b1
    } pool_mode_t;

    typedef enum logic [1:0] {
        S_ACCUM = 2'd0,
        S_DIV   = 2'd1,
        S_CALC  = 2'd2,
        S_OUT   = 2'd3
    } pool_state_t;

    // round(2^recip_bits / num_samples), computed in 64-bit unsigned.
    function automatic longint unsigned calc_recip(input int unsigned num_samples,
                                                   input int unsigned recip_bits);
        longint unsigned scale;
        longint unsigned half;
        scale = 64'd1 << recip_bits;
        half  = 64'(num_samples / 32'd2);
        return (scale + half) / 64'(num_samples);
    endfunction

endpackage

// File: rtl/gap_pool_channel.sv
// One pooling channel: running sum and running signed maximum, followed by
// a registered reciprocal multiply and a registered shift/select stage.
// Optional macro GAP_POOL_MC_ROUND_EN: average rounds half up instead of
// flooring.
module gap_pool_channel
    import fir_cnn_pkg::*;
#(
    parameter int NUM_SAMPLES = 56,
    parameter int WORD_SIZE   = 16,
    parameter int RECIP_BITS  = 24
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        load,
    input  logic                        add,
    input  logic                        div_en,
    input  logic                        calc_en,
    input  pool_mode_t                  mode,
    input  logic signed [WORD_SIZE-1:0] sample,
    output logic signed [WORD_SIZE-1:0] result
);

    localparam int ACC_W   = WORD_SIZE + $clog2(NUM_SAMPLES);
    localparam int RECIP_W = RECIP_BITS + 1;
    localparam int PROD_W  = ACC_W + RECIP_BITS + 2;
    localparam logic [RECIP_W-1:0] RECIP = RECIP_W'(calc_recip(NUM_SAMPLES, RECIP_BITS));
`ifdef GAP_POOL_MC_ROUND_EN
    localparam logic signed [PROD_W-1:0] RND = PROD_W'(64'd1 << (RECIP_BITS - 1));
`else
    localparam logic signed [PROD_W-1:0] RND = '0;
`endif

    logic signed [ACC_W-1:0]     acc_r;
    logic signed [WORD_SIZE-1:0] max_r;
    logic signed [PROD_W-1:0]    prod_r;
    logic signed [WORD_SIZE-1:0] result_r;
    logic signed [ACC_W-1:0]     sample_ext_s;
    logic signed [PROD_W-1:0]    acc_ext_s;
    logic signed [PROD_W-1:0]    recip_ext_s;
    logic signed [PROD_W-1:0]    rounded_s;
    logic signed [WORD_SIZE-1:0] avg_word_s;

    // Sign extension of operands and the rounding/shift of the product.
    always_comb begin
        sample_ext_s = ACC_W'(sample);
        acc_ext_s    = PROD_W'(acc_r);
        recip_ext_s  = $signed(PROD_W'(RECIP));
        rounded_s    = prod_r + RND;
        avg_word_s   = WORD_SIZE'(rounded_s >>> RECIP_BITS);
    end

    // Accumulate/max per beat, multiply in the divide cycle, select in calc.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_r    <= '0;
            max_r    <= '0;
            prod_r   <= '0;
            result_r <= '0;
        end else begin
            if (load) begin
                acc_r <= sample_ext_s;
                max_r <= sample;
            end else if (add) begin
                acc_r <= acc_r + sample_ext_s;
                if (sample > max_r) begin
                    max_r <= sample;
                end
            end
            if (div_en) begin
                prod_r <= acc_ext_s * recip_ext_s;
            end
            if (calc_en) begin
                result_r <= (mode == POOL_MAX) ? max_r : avg_word_s;
            end
        end
    end

    assign result = result_r;

endmodule

// File: rtl/gap_pool_mc_layer.sv
// Multi-channel global average/max pooling layer. A shared FSM and sample
// counter sequence NUM_CHANNELS gap_pool_channel instances.
// Optional macro GAP_POOL_MC_ROUND_EN (see gap_pool_channel).
module gap_pool_mc_layer
    import fir_cnn_pkg::*;
#(
    parameter int NUM_CHANNELS = 3,
    parameter int NUM_SAMPLES  = 56,
    parameter int WORD_SIZE    = 16,
    parameter int INT_BITS     = 8,
    parameter int RECIP_BITS   = 24
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic                                   mode_i,
    input  logic                                   valid_i,
    output logic                                   ready_o,
    input  logic [NUM_CHANNELS-1:0][WORD_SIZE-1:0] data_i,
    output logic                                   valid_o,
    input  logic                                   yumi_i,
    output logic [NUM_CHANNELS-1:0][WORD_SIZE-1:0] data_o
);

    // INT_BITS only documents the fixed-point format; the datapath is
    // format-agnostic because averaging preserves the binary point.
    localparam int FRAC_BITS = WORD_SIZE - INT_BITS;
    localparam int CNT_W     = $clog2(NUM_SAMPLES + 1);

    pool_state_t state_r;
    pool_state_t state_nxt_s;
    logic [CNT_W-1:0] count_r;
    pool_mode_t mode_r;
    logic ready_r;
    logic valid_r;
    logic accept_s;
    logic first_s;
    logic later_s;
    logic last_s;

    // Input handshake decode against the registered ready.
    always_comb begin
        accept_s = valid_i & ready_r;
        first_s  = accept_s & (count_r == '0);
        later_s  = accept_s & (count_r != '0);
        last_s   = accept_s & (count_r == CNT_W'(NUM_SAMPLES - 1));
    end

    // Next-state logic: accumulate, one divide cycle, one calc cycle, hold.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_ACCUM: begin
                if (last_s) begin
                    state_nxt_s = S_DIV;
                end else begin
                    state_nxt_s = S_ACCUM;
                end
            end
            S_DIV:   state_nxt_s = S_CALC;
            S_CALC:  state_nxt_s = S_OUT;
            S_OUT: begin
                if (yumi_i) begin
                    state_nxt_s = S_ACCUM;
                end else begin
                    state_nxt_s = S_OUT;
                end
            end
            default: state_nxt_s = S_ACCUM;
        endcase
    end

    // State, counter, mode latch and registered handshake outputs.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_r <= S_ACCUM;
            count_r <= '0;
            mode_r  <= POOL_AVG;
            ready_r <= 1'b1;
            valid_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            ready_r <= (state_nxt_s == S_ACCUM);
            valid_r <= (state_nxt_s == S_OUT);
            if (accept_s) begin
                count_r <= count_r + CNT_W'(1);
            end else if ((state_r == S_OUT) && yumi_i) begin
                count_r <= '0;
            end
            if (first_s) begin
                mode_r <= pool_mode_t'(mode_i);
            end
        end
    end

    assign ready_o = ready_r;
    assign valid_o = valid_r;

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
        gap_pool_channel #(
            .NUM_SAMPLES (NUM_SAMPLES),
            .WORD_SIZE   (WORD_SIZE),
            .RECIP_BITS  (RECIP_BITS)
        ) u_chan (
            .clk     (clk_i),
            .rst_n   (reset_i),
            .load    (first_s),
            .add     (later_s),
            .div_en  (state_r == S_DIV),
            .calc_en (state_r == S_CALC),
            .mode    (mode_r),
            .sample  (data_i[c]),
            .result  (data_o[c])
        );
    end

    // Keeps the fraction-width parameter referenced for readers and lint.
    logic unused_frac_s;
    assign unused_frac_s = (FRAC_BITS > 0);

endmodule

// File: tb/tb_gap_pool_mc_layer.sv
// Directed bench for gap_pool_mc_layer: one N=4 instance for the main
// scenarios and one N=3 instance for the non-power-of-two reciprocal.
module tb_gap_pool_mc_layer;

    localparam int C = 3;
    localparam int W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic m4, v4, y4, r4, vo4;
    logic [C-1:0][W-1:0] d4, q4;
    logic m3, v3, y3, r3, vo3;
    logic [C-1:0][W-1:0] d3, q3;

    int checks = 0;
    int errors = 0;

    gap_pool_mc_layer #(.NUM_CHANNELS(C), .NUM_SAMPLES(4), .WORD_SIZE(W),
                        .INT_BITS(8), .RECIP_BITS(24)) dut4 (
        .clk_i(clk), .reset_i(rst_n), .mode_i(m4), .valid_i(v4), .ready_o(r4),
        .data_i(d4), .valid_o(vo4), .yumi_i(y4), .data_o(q4));

    gap_pool_mc_layer #(.NUM_CHANNELS(C), .NUM_SAMPLES(3), .WORD_SIZE(W),
                        .INT_BITS(8), .RECIP_BITS(24)) dut3 (
        .clk_i(clk), .reset_i(rst_n), .mode_i(m3), .valid_i(v3), .ready_o(r3),
        .data_i(d3), .valid_o(vo3), .yumi_i(y3), .data_o(q3));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic beat4(input logic m, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c);
        v4 = 1'b1; m4 = m; d4 = {c, b, a};
        tick();
        v4 = 1'b0; m4 = 1'b0;
    endtask

    task automatic beat3(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        v3 = 1'b1; m3 = 1'b0; d3 = {c, b, a};
        tick();
        v3 = 1'b0;
    endtask

    // Called right after the last beat edge: checks uniform 2-cycle latency.
    task automatic result4(input string tag, input logic [47:0] exp, input logic take);
        chk({tag, "_lat0_valid"}, 64'(vo4), 64'd0);
        chk({tag, "_lat0_ready"}, 64'(r4), 64'd0);
        tick();
        chk({tag, "_lat1_valid"}, 64'(vo4), 64'd0);
        tick();
        chk({tag, "_lat2_valid"}, 64'(vo4), 64'd1);
        chk({tag, "_data"}, 64'(q4), 64'(exp));
        if (take) begin
            y4 = 1'b1;
            tick();
            y4 = 1'b0;
            chk({tag, "_post_valid"}, 64'(vo4), 64'd0);
            chk({tag, "_post_ready"}, 64'(r4), 64'd1);
        end
    endtask

    logic [15:0] neg_exp;
    logic [15:0] n3_exp;

    initial begin
`ifdef GAP_POOL_MC_ROUND_EN
        neg_exp = 16'hFFFF;
        n3_exp  = 16'h0100;
`else
        neg_exp = 16'hFFFE;
        n3_exp  = 16'h00FF;
`endif
        rst_n = 1'b0;
        m4 = 1'b0; v4 = 1'b0; y4 = 1'b0; d4 = '0;
        m3 = 1'b0; v3 = 1'b0; y3 = 1'b0; d3 = '0;

        // Reset and idle
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_ready", 64'(r4), 64'd1);
        chk("rst_valid", 64'(vo4), 64'd0);
        chk("rst_data", 64'(q4), 64'd0);
        chk("rst_data3", 64'(q3), 64'd0);
        y4 = 1'b1; y3 = 1'b1;
        tick(); tick();
        y4 = 1'b0; y3 = 1'b0;
        chk("idle_yumi_ready", 64'(r4), 64'd1);
        chk("idle_yumi_valid", 64'(vo4), 64'd0);
        chk("idle_yumi_data", 64'(q4), 64'd0);

        // Average, N=4
        beat4(1'b0, 16'h0100, 16'hFF00, 16'h0001);
        beat4(1'b0, 16'h0200, 16'hFF00, 16'h0000);
        beat4(1'b0, 16'h0300, 16'hFF00, 16'h0000);
        beat4(1'b0, 16'h0400, 16'hFF00, 16'h0000);
        result4("avg4", {16'h0000, 16'hFF00, 16'h0280}, 1'b1);

        // Max mode latched on beat 0; most-negative boundary on ch1
        beat4(1'b1, 16'h8000, 16'h8000, 16'h0001);
        beat4(1'b0, 16'hFFFF, 16'h8000, 16'h0002);
        beat4(1'b0, 16'h0005, 16'h8000, 16'h7FFF);
        beat4(1'b0, 16'h0003, 16'h8000, 16'h0000);
        result4("max4", {16'h7FFF, 16'h8000, 16'h0005}, 1'b0);

        // Backpressure: result held, offered beats refused
        v4 = 1'b1; d4 = {16'h7000, 16'h7000, 16'h7000};
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_valid", 64'(vo4), 64'd1);
            chk("bp_ready", 64'(r4), 64'd0);
            chk("bp_data", 64'(q4), 64'({16'h7FFF, 16'h8000, 16'h0005}));
        end
        y4 = 1'b1;
        tick();
        y4 = 1'b0; v4 = 1'b0;
        chk("bp_yumi_valid", 64'(vo4), 64'd0);
        chk("bp_yumi_ready", 64'(r4), 64'd1);

        // Back-to-back frame; ch2 exercises negative floor/round
        beat4(1'b0, 16'h0040, 16'h0010, 16'hFFFF);
        beat4(1'b0, 16'h0080, 16'h0010, 16'hFFFF);
        beat4(1'b0, 16'h00C0, 16'h0010, 16'hFFFF);
        beat4(1'b0, 16'h0100, 16'h0010, 16'hFFFD);
        result4("b2b", {neg_exp, 16'h0010, 16'h00A0}, 1'b1);

        // Mid-frame reset discards partial accumulation
        beat4(1'b0, 16'h7000, 16'h7000, 16'h7000);
        beat4(1'b0, 16'h7000, 16'h7000, 16'h7000);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mrst_ready", 64'(r4), 64'd1);
        chk("mrst_valid", 64'(vo4), 64'd0);
        chk("mrst_data", 64'(q4), 64'd0);
        for (int i = 0; i < 4; i++) begin
            beat4(1'b0, 16'h0100, 16'h0100, 16'h0100);
        end
        result4("mrst_frame", {16'h0100, 16'h0100, 16'h0100}, 1'b1);

        // Non-power-of-two, N=3
        beat3(16'h0100, 16'h0100, 16'h0100);
        beat3(16'h0100, 16'h0100, 16'h0100);
        beat3(16'h0100, 16'h0100, 16'h0100);
        chk("n3_lat0_valid", 64'(vo3), 64'd0);
        tick();
        chk("n3_lat1_valid", 64'(vo3), 64'd0);
        tick();
        chk("n3_lat2_valid", 64'(vo3), 64'd1);
        chk("n3_data", 64'(q3), 64'({n3_exp, n3_exp, n3_exp}));
        y3 = 1'b1;
        tick();
        y3 = 1'b0;
        chk("n3_post_ready", 64'(r3), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
